// File: rtl/key_event_pkg.sv
// Shared types for the multi-channel key event detector:
// event-select modes, per-channel FSM states and a sizing helper.
package key_event_pkg;

  typedef enum logic [1:0] {
    MODE_RISE     = 2'b00,
    MODE_FALL     = 2'b01,
    MODE_BOTH     = 2'b10,
    MODE_RISE_RPT = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    IDLE_S = 2'b00,
    EDGE_S = 2'b01,
    HOLD_S = 2'b10,
    RPT_S  = 2'b11
  } state_e;

  function automatic int max2(int a, int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/key_event_channel.sv
// One key: input synchroniser, integrating debouncer and
// press/hold/repeat FSM producing registered one-cycle pulses.
module key_event_channel
  import key_event_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int HOLD_CYCLES     = 1000,
  parameter int REPEAT_CYCLES   = 200
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic pressed,
  output logic rise,
  output logic fall,
  output logic rpt
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int CW = $clog2(max2(HOLD_CYCLES, REPEAT_CYCLES) + 1);
  localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_IDX = CW'(HOLD_CYCLES);
  localparam logic [CW-1:0] RPT_IDX  = CW'(REPEAT_CYCLES);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [DW-1:0]          db_cnt;
  logic [CW-1:0]          hc;
  logic [CW-1:0]          hc_inc;
  logic                   sync;
  logic                   flip;
  state_e                 state;

  assign sync   = sync_q[SYNC_STAGES-1];
  assign flip   = (sync != pressed) && (db_cnt == DB_LAST);
  assign hc_inc = hc + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q  <= '0;
      db_cnt  <= '0;
      hc      <= '0;
      pressed <= 1'b0;
      rise    <= 1'b0;
      fall    <= 1'b0;
      rpt     <= 1'b0;
      state   <= IDLE_S;
    end else begin
      sync_q <= SYNC_STAGES'({sync_q, raw});
      rise   <= 1'b0;
      fall   <= 1'b0;
      rpt    <= 1'b0;
      if (sync == pressed || flip) db_cnt <= '0;
      else                         db_cnt <= db_cnt + 1'b1;
      // A level flip outranks any repeat due in the same cycle.
      if (flip) begin
        pressed <= sync;
        hc      <= '0;
        if (sync) begin
          state <= EDGE_S;
          rise  <= 1'b1;
        end else begin
          state <= IDLE_S;
          fall  <= 1'b1;
        end
      end else begin
        unique case (state)
          EDGE_S, HOLD_S: begin
            if (hc_inc == HOLD_IDX) begin
              rpt <= 1'b1;
              if (REPEAT_CYCLES > 0) begin
                state <= RPT_S;
                hc    <= '0;
              end else begin
                state <= HOLD_S;
                hc    <= HOLD_IDX;
              end
            end else begin
              state <= HOLD_S;
              if (hc != HOLD_IDX) hc <= hc_inc;
            end
          end
          RPT_S: begin
            if (hc_inc == RPT_IDX) begin
              rpt <= 1'b1;
              hc  <= '0;
            end else begin
              hc <= hc_inc;
            end
          end
          default: state <= IDLE_S;
        endcase
      end
    end
  end

endmodule

// File: rtl/key_event_detector.sv
// Multi-channel keypad event block: per-channel detectors plus
// mode-selected event vector and its OR-reduction.
module key_event_detector
  import key_event_pkg::*;
#(
  parameter int CHANNELS        = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int HOLD_CYCLES     = 1000,
  parameter int REPEAT_CYCLES   = 200
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic [CHANNELS-1:0] raw_i,
  input  logic [1:0]          edge_mode_i,
  output logic [CHANNELS-1:0] pressed_o,
  output logic [CHANNELS-1:0] rise_o,
  output logic [CHANNELS-1:0] fall_o,
  output logic [CHANNELS-1:0] repeat_o,
  output logic [CHANNELS-1:0] event_o,
  output logic                any_event_o
);

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    key_event_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .HOLD_CYCLES    (HOLD_CYCLES),
      .REPEAT_CYCLES  (REPEAT_CYCLES)
    ) u_ch (
      .clk    (clk_i),
      .reset  (reset_i),
      .raw    (raw_i[g]),
      .pressed(pressed_o[g]),
      .rise   (rise_o[g]),
      .fall   (fall_o[g]),
      .rpt    (repeat_o[g])
    );
  end

  always_comb begin
    event_o = '0;
    unique case (mode_e'(edge_mode_i))
      MODE_RISE:     event_o = rise_o;
      MODE_FALL:     event_o = fall_o;
      MODE_BOTH:     event_o = rise_o | fall_o;
      MODE_RISE_RPT: event_o = rise_o | repeat_o;
    endcase
  end

  assign any_event_o = |event_o;

endmodule

// File: tb/tb_key_event_detector.sv
// Randomised bench for key_event_detector with a behavioural
// reference model plus directed literal checks.
module tb_key_event_detector;

  localparam int CH = 2;
  localparam int SS = 2;
  localparam int DB = 4;
  localparam int HC = 10;
  localparam int RC = 3;

  logic          clk = 1'b0;
  logic          reset_i = 1'b1;
  logic [CH-1:0] raw_i = '0;
  logic [1:0]    edge_mode_i = 2'b00;
  logic [CH-1:0] pressed_o, rise_o, fall_o, repeat_o, event_o;
  logic          any_event_o;

  key_event_detector #(
    .CHANNELS(CH), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DB),
    .HOLD_CYCLES(HC), .REPEAT_CYCLES(RC)
  ) dut (
    .clk_i(clk), .reset_i(reset_i), .raw_i(raw_i),
    .edge_mode_i(edge_mode_i), .pressed_o(pressed_o),
    .rise_o(rise_o), .fall_o(fall_o), .repeat_o(repeat_o),
    .event_o(event_o), .any_event_o(any_event_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: sync is raw delayed SS edges; level flips after
  // DB consecutive disagreeing samples; repeats by press age.
  bit [SS-1:0]   m_sync [CH];
  int            m_run  [CH];
  bit            m_lvl  [CH];
  int            m_age  [CH];
  bit            m_s;
  logic [CH-1:0] e_pr = '0, e_ri = '0, e_fa = '0, e_rp = '0, e_ev;

  always begin
    @(posedge clk);
    e_ri = '0;
    e_fa = '0;
    e_rp = '0;
    if (reset_i) begin
      for (int c = 0; c < CH; c++) begin
        m_sync[c] = '0; m_run[c] = 0; m_lvl[c] = 0; m_age[c] = 0;
      end
      e_pr = '0;
    end else begin
      for (int c = 0; c < CH; c++) begin
        m_s = m_sync[c][SS-1];
        m_sync[c] = {m_sync[c][SS-2:0], raw_i[c]};
        if (m_s != m_lvl[c]) m_run[c]++;
        else m_run[c] = 0;
        if (m_run[c] == DB) begin
          m_run[c] = 0;
          m_lvl[c] = m_s;
          if (m_s) begin
            e_ri[c] = 1'b1;
            m_age[c] = 0;
          end else begin
            e_fa[c] = 1'b1;
          end
        end else if (m_lvl[c]) begin
          m_age[c]++;
          if (m_age[c] >= HC &&
              (RC == 0 ? m_age[c] == HC : (m_age[c] - HC) % RC == 0))
            e_rp[c] = 1'b1;
        end
        e_pr[c] = m_lvl[c];
      end
    end
    #1;
    case (edge_mode_i)
      2'b00:   e_ev = e_ri;
      2'b01:   e_ev = e_fa;
      2'b10:   e_ev = e_ri | e_fa;
      default: e_ev = e_ri | e_rp;
    endcase
    chk("pressed", pressed_o, e_pr);
    chk("rise", rise_o, e_ri);
    chk("fall", fall_o, e_fa);
    chk("repeat", repeat_o, e_rp);
    chk("event", event_o, e_ev);
    chk("any_event", any_event_o, |e_ev);
  end

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  int cnt;
  int flag;
  int rem [CH];

  initial begin
    cyc(3);
    chk("reset_outputs", {pressed_o, rise_o, fall_o, repeat_o, event_o, any_event_o}, '0);
    reset_i = 1'b0;
    cyc(2);

    // Clean press on channel 0, mode 00
    raw_i[0] = 1'b1;
    cyc(5);
    chk("press_not_yet", pressed_o[0], 1'b0);
    cyc(1);
    chk("press_edge6", pressed_o[0], 1'b1);
    chk("rise_pulse", rise_o[0], 1'b1);
    chk("rise_event_m00", event_o[0], 1'b1);
    cyc(9);
    chk("no_repeat_idx9", repeat_o[0], 1'b0);
    cyc(1);
    chk("repeat_idx10", repeat_o[0], 1'b1);
    chk("m00_hides_repeat", event_o[0], 1'b0);
    cyc(3);
    chk("repeat_idx13", repeat_o[0], 1'b1);
    cyc(6);

    // Release in mode 01; fall lands on a due repeat (index 25)
    raw_i[0] = 1'b0;
    edge_mode_i = 2'b01;
    cyc(5);
    chk("release_not_yet", pressed_o[0], 1'b1);
    cyc(1);
    chk("release_edge6", pressed_o[0], 1'b0);
    chk("fall_pulse", fall_o[0], 1'b1);
    chk("fall_event_m01", event_o[0], 1'b1);
    chk("fall_beats_repeat", repeat_o[0], 1'b0);
    flag = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      flag |= repeat_o[0] | fall_o[0];
    end
    chk("quiet_after_release", flag, 0);

    // Bounce on channel 1
    flag = 0;
    for (int i = 0; i < 18; i++) begin
      if (i < 10) raw_i[1] = ~raw_i[1];
      for (int k = 0; k < 2; k++) begin
        cyc(1);
        flag |= pressed_o[1] | rise_o[1] | fall_o[1] | repeat_o[1];
      end
    end
    chk("bounce_silent", flag, 0);

    // Mode 10: short press gives rise and fall only
    edge_mode_i = 2'b10;
    raw_i[0] = 1'b1;
    cnt = 0;
    for (int i = 0; i < 22; i++) begin
      if (i == 8) raw_i[0] = 1'b0;
      cyc(1);
      cnt += event_o[0];
    end
    chk("m10_two_events", cnt, 2);

    // Mode 11: rise plus repeats at indices 10,13,16,19
    edge_mode_i = 2'b11;
    raw_i[0] = 1'b1;
    cnt = 0;
    for (int i = 0; i < 32; i++) begin
      if (i == 20) raw_i[0] = 1'b0;
      cyc(1);
      cnt += event_o[0];
    end
    chk("m11_five_events", cnt, 5);

    // Reset during RPT_S with key held
    edge_mode_i = 2'b00;
    raw_i[0] = 1'b1;
    cyc(18);
    reset_i = 1'b1;
    cyc(1);
    chk("reset_mid_hold", {pressed_o, rise_o, fall_o, repeat_o, event_o, any_event_o}, '0);
    reset_i = 1'b0;
    cyc(5);
    chk("no_rise_early", rise_o[0], 1'b0);
    cyc(1);
    chk("rise_after_reset", rise_o[0], 1'b1);
    raw_i[0] = 1'b0;
    cyc(12);

    // Simultaneous press on both channels
    raw_i = 2'b11;
    cyc(5);
    chk("sim_any_early", any_event_o, 1'b0);
    cyc(1);
    chk("sim_rise_both", rise_o, 2'b11);
    chk("sim_any_high", any_event_o, 1'b1);
    cyc(1);
    chk("sim_any_one_cycle", any_event_o, 1'b0);
    raw_i = 2'b00;
    cyc(12);

    // Randomised phase, checked cycle by cycle against the model
    for (int c = 0; c < CH; c++) rem[c] = $urandom_range(1, 30);
    for (int i = 0; i < 4000; i++) begin
      for (int c = 0; c < CH; c++) begin
        rem[c]--;
        if (rem[c] == 0) begin
          raw_i[c] = ~raw_i[c];
          rem[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4)
                                               : $urandom_range(5, 40);
        end
      end
      if ($urandom_range(0, 15) == 0) edge_mode_i = 2'($urandom_range(0, 3));
      reset_i = ($urandom_range(0, 399) == 0);
      cyc(1);
    end
    reset_i = 1'b0;
    cyc(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_event_detector.md
Name: key_event_detector

Overview:
- Parametrised multi-channel keypad event block; successor to the single-channel debounce-input edge FSM in the kpyd path.
- Per channel: input synchroniser, integrating debouncer, press/hold/repeat FSM.
- Produces a debounced level, one-cycle rise/fall pulses, auto-repeat pulses, and a mode-selected event vector for the keypad scanner/decoder.

Parameters:
- CHANNELS, 4: number of independent key inputs (>=1).
- SYNC_STAGES, 2: flops in each input synchroniser (>=1).
- DEBOUNCE_CYCLES, 16: consecutive cycles of a new level required before the debounced level flips (>=1).
- HOLD_CYCLES, 1000: cycles pressed before the first repeat pulse (>=1).
- REPEAT_CYCLES, 200: period between subsequent repeat pulses; 0 disables repeat.

Ports:
- clk_i  input  1  clock
- reset_i  input  1  synchronous active-high reset
- raw_i  input  CHANNELS  asynchronous raw key levels, 1 = pressed
- edge_mode_i  input  2  event select: 00 rise, 01 fall, 10 both, 11 rise|repeat
- pressed_o  output  CHANNELS  debounced level per channel
- rise_o  output  CHANNELS  one-cycle pulse on debounced 0->1
- fall_o  output  CHANNELS  one-cycle pulse on debounced 1->0
- repeat_o  output  CHANNELS  one-cycle auto-repeat pulse
- event_o  output  CHANNELS  pulses selected by edge_mode_i
- any_event_o  output  1  OR-reduction of event_o

Behaviour:
- Interface: one clock, clk_i. reset_i is synchronous and active-high.
- Reset state: all synchroniser flops, debounced levels, counters and FSMs clear to 0/IDLE_S. Every output is 0 in the cycle after reset_i is sampled high.
- Synchroniser: raw_i passes through SYNC_STAGES flops; sync = last stage.
- Debounce counter:
  - Width $clog2(DEBOUNCE_CYCLES+1).
  - Counter clears whenever sync equals the stable level.
  - When sync differs and count == DEBOUNCE_CYCLES-1, the stable level flips and the counter clears; otherwise it increments.
- Latency: counting the first edge that samples the new raw_i level as edge 1, pressed_o changes after edge SYNC_STAGES+DEBOUNCE_CYCLES.
- Bounce: any glitch shorter than DEBOUNCE_CYCLES sync cycles produces no change and no pulses.
- FSM per channel, states IDLE_S, EDGE_S, HOLD_S, RPT_S:
  - IDLE_S -> EDGE_S when the stable level becomes 1. rise_o is high in that same cycle, concurrent with the first cycle of pressed_o=1.
  - EDGE_S lasts exactly 1 cycle, then goes to HOLD_S. The hold counter starts at 0 in the EDGE_S cycle.
  - HOLD_S: repeat_o pulses when the pressed cycle index reaches HOLD_CYCLES (index 0 = rise cycle). If REPEAT_CYCLES>0, go to RPT_S; otherwise stay in HOLD_S with the counter saturated.
  - RPT_S: repeat_o pulses every REPEAT_CYCLES cycles after the previous repeat.
  - Any state -> IDLE_S when the stable level becomes 0. fall_o is high that cycle, concurrent with the first cycle of pressed_o=0.
- Simultaneous events: if release coincides with a due repeat, fall_o fires and repeat_o does not.
- Pulse invariants: rise_o and fall_o are never high together on one channel. Pulses are registered outputs.
- event_o:
  - Combinational from the registered pulses and edge_mode_i.
  - 00 = rise_o; 01 = fall_o; 10 = rise_o|fall_o; 11 = rise_o|repeat_o.
  - A mode change takes effect the same cycle.
- Counter widths: the hold/repeat counter is $clog2(max(HOLD_CYCLES,REPEAT_CYCLES)+1) bits and never wraps (it saturates).
- Channels are fully independent; simultaneous events on several channels all pulse in the same cycle, and any_event_o is high for 1 cycle.
- Reset mid-press: outputs drop to 0 with no fall pulse. If raw_i stays high, a fresh rise_o appears at full latency after reset deasserts.

Decomposition:
- key_event_pkg holds:
  - the mode enum (MODE_RISE, MODE_FALL, MODE_BOTH, MODE_RISE_RPT)
  - the FSM state enum (IDLE_S, EDGE_S, HOLD_S, RPT_S)
- key_event_channel is one sub-module: single-channel synchroniser + debouncer + FSM with scalar ports. The top level generates CHANNELS instances and does event selection and the OR-reduction.
- Expected size ~200-300 lines total.

Test Plan:
(Bench parameters: CHANNELS=2, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, HOLD_CYCLES=10, REPEAT_CYCLES=3.)
- Clean press: raw_i[0]=1 held 25 cycles -> pressed_o[0] rises after edge 6; rise_o[0] pulses once that cycle; repeat_o[0] pulses 10 cycles after rise, then every 3 cycles.
- Bounce: raw_i[1] toggles every 2 cycles for 20 cycles, then returns to 0 -> pressed_o, rise_o, fall_o and repeat_o on channel 1 stay 0 throughout.
- Release: after the clean press, drop raw_i[0] with edge_mode_i=01 -> pressed_o[0] falls after 6 edges; fall_o[0] and event_o[0] pulse for 1 cycle; no repeat after release.
- Modes and repeat: press and release channel 0 with edge_mode_i=10, then press with edge_mode_i=11 held 20 cycles.
  - Mode 10: event_o[0] pulses exactly twice.
  - Mode 11: event_o[0] pulses at rise and at each repeat.
  - Mode 00: repeat pulses do not appear on event_o.
- Reset and simultaneous channels:
  - Reset mid-hold: assert reset_i 1 cycle during RPT_S with raw_i[0] held high -> all outputs 0 the next cycle, no fall_o; a rise_o[0] appears 6 edges after reset deasserts.
  - Simultaneous press: raw_i=2'b11 on the same edge -> rise_o=2'b11 in the same cycle and any_event_o high for exactly 1 cycle.
